icache_ctrl_nway: RTL
=====================

Name: icache_ctrl_nway

Overview:
Parametrised N-way set-associative instruction-cache controller. It replaces the fixed 2-way controller.
- Sits between the IF stage and the external tag/data SRAM arrays, and requests line refills from L2.
- Adds tree pseudo-LRU replacement held internally, an automatic post-reset invalidate sweep, and a software flush command.
- Adds critical-word forwarding on refill.

Parameters:
ADDR_W, 30, word-address width of if_addr
WAYS, 2, associativity; legal values 2, 4, 8
INDEX_W, 8, set-index bits (SETS = 2**INDEX_W)
OFFSET_W, 2, word-in-line bits (LINE_W = 32 << OFFSET_W)
Derived localparams: TAG_W = ADDR_W-INDEX_W-OFFSET_W; TE_W = TAG_W+1 (valid bit at MSB).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_addr  in  ADDR_W  fetch word address; held stable by IF until data_rdy
if_req  in  1  fetch request valid
cpu_data  out  32  fetched instruction
data_rdy  out  1  cpu_data valid this cycle
miss_stall  out  1  IF must stall
index  out  INDEX_W  array set address
block_re  out  1  array read enable
tag_rd  in  WAYS*TE_W  per-way tag entries; way w at [w*TE_W +: TE_W]
data_rd  in  WAYS*LINE_W  per-way lines
way_we  out  WAYS  per-way write enable (tag and data)
tag_wd  out  TE_W  tag write data
data_wd  out  LINE_W  line write data
irq  out  1  L2 refill request
l2_addr  out  ADDR_W-OFFSET_W  line address of refill
ic_en  in  1  L2 grants the icache port
l2_rdy  in  1  one-cycle pulse: l2_data valid
l2_data  in  LINE_W  refill line
flush  in  1  invalidate-all request (pulse)
flush_done  out  1  one-cycle pulse at sweep end

Behaviour:
- Arrays have a synchronous read: an index presented in cycle N gives tag_rd/data_rd in cycle N+1.
- Address split: word = if_addr[OFFSET_W-1:0]; set = next INDEX_W bits; tag = upper TAG_W bits.
- States: FLUSH, IDLE, ACCESS, MISS_REQ, MISS_WAIT, FILL.
- Reset: state=FLUSH, sweep counter=0, all PLRU bits=0, flush_pending=0, lk_addr=0. All outputs are 0 except miss_stall=1.
- Reset mid-miss abandons the refill: irq is low the cycle after reset. Any late l2_rdy is ignored.
- FLUSH:
  - index=counter, way_we=all ones, tag_wd=0; the counter increments each cycle.
  - After SETS cycles, flush_done pulses in the final sweep cycle and the block goes to IDLE.
  - miss_stall=1 throughout.
- IDLE: index=if_addr set, block_re=1; lk_addr<=if_addr; go to ACCESS.
- ACCESS:
  - index=if_addr set, block_re=1 every cycle; lk_addr<=if_addr.
  - hit_w = tag_rd[w] valid and tag == lk_addr tag.
  - A hit is qualified by if_req and lk_addr==if_addr. On a hit: data_rdy=1, cpu_data = word of the hit way's line, and the PLRU for that set is updated to make the hit way MRU.
  - If lk_addr!=if_addr, the cycle is a re-lookup: no data_rdy, no miss.
  - Miss (no way hits, if_req=1, addresses match):
    - latch miss_addr and victim (lowest-numbered invalid way, else PLRU victim);
    - miss_stall=1;
    - go to MISS_REQ.
  - More than one way hitting is an illegal state; the lowest-numbered way wins.
- MISS_REQ: irq=1, l2_addr=miss_addr line; on ic_en=1 go to MISS_WAIT.
- MISS_WAIT:
  - irq=1 stays asserted.
  - If ic_en drops before l2_rdy, return to MISS_REQ.
  - On l2_rdy go to FILL with the line captured.
- FILL (exactly one cycle):
  - way_we[victim]=1, index=miss set, tag_wd={1,miss tag}, data_wd=captured line.
  - data_rdy=1 with cpu_data = critical word; miss_stall=0; irq=0; PLRU marks the victim MRU.
  - Next state: FLUSH if flush_pending, else IDLE.
- Flush handling: flush in IDLE or ACCESS goes to FLUSH next cycle, taking priority over a same-cycle hit (no data_rdy). Flush during MISS_*/FILL sets flush_pending, which is serviced after FILL.
- PLRU: WAYS-1 bits per set. Tree bit=0 means "victim on left". Updating on access sets the bits along the path to point away from the accessed way.
- Outputs not listed for a state are 0.

Decomposition:
- Shared header icache.h: state encodings and ENABLE/DISABLE.
- Sub-module icache_plru: parametrised on WAYS.
  - Combinational: victim = f(tree bits); next bits = f(bits, way).
  - The controller holds the SETS x (WAYS-1) register file.

Test Plan:
Use WAYS=4, INDEX_W=8, OFFSET_W=2.
1. Reset → miss_stall=1 for 256 cycles, way_we=4'hF, tag_wd=0; flush_done pulses on cycle 256; then IDLE.
2. Fetch if_addr=0x0000123 (cold) → irq=1, l2_addr=0x0000048; grant, then l2_rdy with line {D3,D2,D1,D0} → FILL way_we=4'b0001, tag_wd={1,0x00000}, cpu_data=D3, data_rdy=1.
3. Refetch 0x0000120 after the fill → data_rdy one cycle after the lookup, cpu_data=D0, no irq.
4. Five distinct tags to set 0x48:
   - fills go to ways 0,1,2,3;
   - after accesses to ways 0,1,2,3, the fifth miss replaces way 0 (PLRU victim).
5. ic_en deasserted in MISS_WAIT → returns to MISS_REQ with irq held high; refill completes on regrant.
6. flush pulsed during MISS_WAIT → the refill completes with data_rdy, then a 256-cycle sweep and flush_done; the next fetch misses.

Source files
------------

// File: rtl/icache_ctrl_nway_pkg.sv
// Shared constants for the N-way instruction cache controller.
package icache_ctrl_nway_pkg;

  localparam logic [2:0] StFlush    = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StAccess   = 3'd2;
  localparam logic [2:0] StMissReq  = 3'd3;
  localparam logic [2:0] StMissWait = 3'd4;
  localparam logic [2:0] StFill     = 3'd5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/icache_ctrl_nway_plru.sv
// Tree pseudo-LRU for one set: victim lookup and MRU update (bit=0 means victim on the left).
module icache_ctrl_nway_plru #(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WayW  = $clog2(WAYS),
  localparam int unsigned NodeW = (WAYS > 2) ? $clog2(WAYS - 1) : 1
) (
  input  logic [WAYS-2:0] bits_i,
  input  logic [WayW-1:0] way_i,
  output logic [WayW-1:0] victim_o,
  output logic [WAYS-2:0] bits_o
);

  logic [NodeW-1:0] v_node, u_node;
  logic             v_dir, u_dir;
  logic [WayW-1:0]  u_way;

  // Heap-ordered tree: children of node n are 2n+1 (left) and 2n+2 (right).
  always_comb begin
    victim_o = '0;
    v_node   = '0;
    v_dir    = 1'b0;
    for (int l = 0; l < WayW; l++) begin
      v_dir    = bits_i[v_node];
      victim_o = WayW'({victim_o, v_dir});
      v_node   = NodeW'(2 * int'(v_node) + 1 + int'(v_dir));
    end
  end

  always_comb begin
    bits_o = bits_i;
    u_node = '0;
    u_dir  = 1'b0;
    u_way  = way_i;
    for (int l = 0; l < WayW; l++) begin
      u_dir          = u_way[WayW-1];
      bits_o[u_node] = ~u_dir;
      u_node         = NodeW'(2 * int'(u_node) + 1 + int'(u_dir));
      u_way          = u_way << 1;
    end
  end

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction cache controller: lookup, L2 refill with
// critical-word forwarding, invalidate sweep after reset/flush, tree-PLRU replacement.
module icache_ctrl_nway
  import icache_ctrl_nway_pkg::*;
#(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 2,
  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned TE_W   = TAG_W + 1,
  localparam int unsigned LINE_W = 32 << OFFSET_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      if_addr,
  input  logic                   if_req,
  output logic [31:0]            cpu_data,
  output logic                   data_rdy,
  output logic                   miss_stall,
  output logic [INDEX_W-1:0]     index,
  output logic                   block_re,
  input  logic [WAYS*TE_W-1:0]   tag_rd,
  input  logic [WAYS*LINE_W-1:0] data_rd,
  output logic [WAYS-1:0]        way_we,
  output logic [TE_W-1:0]        tag_wd,
  output logic [LINE_W-1:0]      data_wd,
  output logic                   irq,
  output logic [ADDR_W-OFFSET_W-1:0] l2_addr,
  input  logic                   ic_en,
  input  logic                   l2_rdy,
  input  logic [LINE_W-1:0]      l2_data,
  input  logic                   flush,
  output logic                   flush_done
);

  localparam int unsigned SETS = 1 << INDEX_W;
  localparam int unsigned WayW = $clog2(WAYS);

  logic [2:0]          state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0]   lk_addr_q, lk_addr_d, miss_addr_q, miss_addr_d;
  logic [WayW-1:0]     victim_q, victim_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WAYS-2:0]     plru_q [SETS];

  logic                plru_we;
  logic [INDEX_W-1:0]  plru_set;
  logic [WayW-1:0]     plru_way, plru_victim;
  logic [WAYS-2:0]     plru_bits_next;

  logic [INDEX_W-1:0]  if_set, lk_set, miss_set;
  logic [TAG_W-1:0]    lk_tag, miss_tag;
  logic [OFFSET_W-1:0] lk_word, miss_word;

  logic                hit_any, inv_any;
  logic [WayW-1:0]     hit_way, inv_way;
  logic [LINE_W-1:0]   hit_line;
  logic [TE_W-1:0]     tag_e;

  assign if_set    = if_addr[OFFSET_W +: INDEX_W];
  assign lk_set    = lk_addr_q[OFFSET_W +: INDEX_W];
  assign lk_tag    = lk_addr_q[ADDR_W-1 -: TAG_W];
  assign lk_word   = lk_addr_q[OFFSET_W-1:0];
  assign miss_set  = miss_addr_q[OFFSET_W +: INDEX_W];
  assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
  assign miss_word = miss_addr_q[OFFSET_W-1:0];

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    inv_any  = 1'b0;
    inv_way  = '0;
    tag_e    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      tag_e = tag_rd[w*TE_W +: TE_W];
      if (tag_e[TE_W-1] && (tag_e[TAG_W-1:0] == lk_tag)) begin
        hit_any  = 1'b1;
        hit_way  = WayW'(w);
        hit_line = data_rd[w*LINE_W +: LINE_W];
      end
      if (!tag_e[TE_W-1]) begin
        inv_any = 1'b1;
        inv_way = WayW'(w);
      end
    end
  end

  assign plru_set = (state_q == StFill) ? miss_set : lk_set;
  assign plru_way = (state_q == StFill) ? victim_q : hit_way;

  icache_ctrl_nway_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .bits_i  (plru_q[plru_set]),
    .way_i   (plru_way),
    .victim_o(plru_victim),
    .bits_o  (plru_bits_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    flush_pend_d = flush_pend_q;
    lk_addr_d    = lk_addr_q;
    miss_addr_d  = miss_addr_q;
    victim_d     = victim_q;
    line_d       = line_q;
    plru_we      = DISABLE;
    cpu_data     = '0;
    data_rdy     = DISABLE;
    miss_stall   = DISABLE;
    index        = '0;
    block_re     = DISABLE;
    way_we       = '0;
    tag_wd       = '0;
    data_wd      = '0;
    irq          = DISABLE;
    l2_addr      = '0;
    flush_done   = DISABLE;

    case (state_q)
      StFlush: begin
        index        = cnt_q;
        way_we       = '1;
        miss_stall   = ENABLE;
        cnt_d        = cnt_q + 1'b1;
        flush_pend_d = 1'b0;
        if (&cnt_q) begin
          flush_done = ENABLE;
          state_d    = StIdle;
        end
      end
      StIdle: begin
        index     = if_set;
        block_re  = ENABLE;
        lk_addr_d = if_addr;
        state_d   = flush ? StFlush : StAccess;
      end
      StAccess: begin
        index     = if_set;
        block_re  = ENABLE;
        lk_addr_d = if_addr;
        if (flush) begin
          state_d = StFlush;
        end else if (if_req && (lk_addr_q == if_addr)) begin
          if (hit_any) begin
            data_rdy = ENABLE;
            cpu_data = hit_line[32*lk_word +: 32];
            plru_we  = ENABLE;
          end else begin
            miss_addr_d = lk_addr_q;
            victim_d    = inv_any ? inv_way : plru_victim;
            miss_stall  = ENABLE;
            state_d     = StMissReq;
          end
        end
      end
      StMissReq: begin
        irq        = ENABLE;
        l2_addr    = miss_addr_q[ADDR_W-1:OFFSET_W];
        miss_stall = ENABLE;
        if (flush) flush_pend_d = 1'b1;
        if (ic_en) state_d = StMissWait;
      end
      StMissWait: begin
        irq        = ENABLE;
        l2_addr    = miss_addr_q[ADDR_W-1:OFFSET_W];
        miss_stall = ENABLE;
        if (flush) flush_pend_d = 1'b1;
        if (l2_rdy) begin
          line_d  = l2_data;
          state_d = StFill;
        end else if (!ic_en) begin
          state_d = StMissReq;
        end
      end
      StFill: begin
        way_we       = WAYS'(1) << victim_q;
        index        = miss_set;
        tag_wd       = {1'b1, miss_tag};
        data_wd      = line_q;
        data_rdy     = ENABLE;
        cpu_data     = line_q[32*miss_word +: 32];
        plru_we      = ENABLE;
        flush_pend_d = 1'b0;
        state_d      = (flush_pend_q || flush) ? StFlush : StIdle;
      end
      default: state_d = StFlush;
    endcase

    // Outputs stay quiet while reset is held; the sweep starts once it is released.
    if (rst) begin
      cpu_data   = '0;
      data_rdy   = DISABLE;
      miss_stall = ENABLE;
      index      = '0;
      block_re   = DISABLE;
      way_we     = '0;
      tag_wd     = '0;
      data_wd    = '0;
      irq        = DISABLE;
      l2_addr    = '0;
      flush_done = DISABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFlush;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      lk_addr_q    <= '0;
      miss_addr_q  <= '0;
      victim_q     <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      lk_addr_q    <= lk_addr_d;
      miss_addr_q  <= miss_addr_d;
      victim_q     <= victim_d;
      line_q       <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[plru_set] <= plru_bits_next;
    end
  end

endmodule
